// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path: FSM state encoding and
// the post-reset guard interval used by uart_tx_fifo.
package uart_pkg;

  typedef enum logic [1:0] {
    GUARD,
    IDLE,
    ISSUE,
    WAIT_DONE
  } uart_tx_fifo_state_t;

  localparam int unsigned GUARD_CNT_W = 32;

  // One full 10-bit frame plus margin, so a byte already inside uart_tx can drain.
  function automatic logic [GUARD_CNT_W-1:0] guard_count(input int unsigned ccs_per_bit);
    return GUARD_CNT_W'(10 * ccs_per_bit + 2);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; combinational head read, write and
// pop may coincide even when full.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty;
  logic             wr_ok;
  logic             rd_ok;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop in the same cycle frees the slot the write lands in.
  assign wr_ok  = wr_en_i && (!full_o || rd_en_i);
  assign rd_ok  = rd_en_i && !empty;

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: issues one start pulse per byte, waits for the
// done rising edge. Define UART_TX_FIFO_LEVEL_EN to expose the level_o port.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CCS_PER_BIT = 217,
  parameter int DEPTH       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             wr_byte_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  output logic [7:0]             tx_byte_o,
  output logic                   tx_valid_o,
  input  logic                   tx_done_i,
  output logic                   busy_o
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level_o
`endif
);
  localparam logic [GUARD_CNT_W-1:0] GUARD_INIT = guard_count(CCS_PER_BIT);

  uart_tx_fifo_state_t      state_q, state_d;
  logic [GUARD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]               tx_byte_q, tx_byte_d;
  logic                     done_prev_q, done_prev_d;
  logic                     done_rise;
  logic                     pop;
  logic                     push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [7:0]               fifo_head;
  logic [$clog2(DEPTH):0]   fifo_count;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (push),
    .wr_data_i (wr_byte_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .count_o   (fifo_count)
  );

  assign fifo_empty = (fifo_count == '0);
  assign done_rise  = tx_done_i && !done_prev_q;
  assign push       = wr_valid_i && wr_ready_o;
  assign tx_byte_o  = tx_byte_q;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level_o = fifo_count;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= GUARD;
      cnt_q       <= GUARD_INIT;
      tx_byte_q   <= 8'h00;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      done_prev_q <= done_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_prev_d = tx_done_i;
    case (state_q)
      GUARD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      IDLE:      if (!fifo_empty) state_d = ISSUE;
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: if (done_rise) state_d = IDLE;
      default:   state_d = GUARD;
    endcase
  end

  // Ready also opens on a full FIFO whenever the head is popped this cycle.
  always_comb begin
    pop        = (state_q == IDLE) && !fifo_empty;
    tx_byte_d  = pop ? fifo_head : tx_byte_q;
    tx_valid_o = (state_q == ISSUE) && !rst_i;
    wr_ready_o = !rst_i && (!fifo_full || pop);
    busy_o     = !fifo_empty || (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a scoreboard of expected transmit bytes
// and a small uart_tx model that raises tx_done_i for two cycles.
module tb_uart_tx_fifo;
  localparam int CCS   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] wr_byte_i;
  logic       wr_valid_i;
  logic       wr_ready_o;
  logic [7:0] tx_byte_o;
  logic       tx_valid_o;
  logic       tx_done_i;
  logic       busy_o;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [LW-1:0] level_o;
`endif

  uart_tx_fifo #(.CCS_PER_BIT(CCS), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_byte_i  (wr_byte_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .tx_byte_o  (tx_byte_o),
    .tx_valid_o (tx_valid_o),
    .tx_done_i  (tx_done_i),
    .busy_o     (busy_o)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level_o    (level_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_pass = 0;
  int         tx_count = 0;
  int         last_tx_cyc = -100;
  int         done_rise_cyc = -100;
  int         done_dly = 4;
  bit         b2b_en = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_tx(input int target, input int budget, input string name);
    int k = 0;
    while (tx_count < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, tx_count, target);
  endtask

  // Offers a byte and holds it until accepted; acc is the accepting cycle.
  task automatic send(input logic [7:0] b, output int acc);
    int k = 0;
    acc = -1;
    wr_byte_i  = b;
    wr_valid_i = 1'b1;
    while (!wr_ready_o && k < 200) begin
      tick();
      k++;
    end
    if (wr_ready_o) acc = cyc;
    tick();
    wr_valid_i = 1'b0;
    chk("send_accept", 32'(acc >= 0), 1);
  endtask

  // Monitor: every start pulse must match the scoreboard head.
  always @(negedge clk_i) begin
    if (tx_valid_o) begin
      tx_count++;
      chk("tx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("tx_byte", tx_byte_o, exp_q.pop_front());
      if (b2b_en && done_rise_cyc > last_tx_cyc) chk("b2b_latency", cyc, done_rise_cyc + 2);
      last_tx_cyc = cyc;
    end
  end

  // uart_tx model: done rises done_dly cycles after a start, stays high 2 cycles.
  initial begin
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (tx_valid_o) begin
        repeat (done_dly) @(posedge clk_i);
        #1;
        tx_done_i     = 1'b1;
        done_rise_cyc = cyc;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        tx_done_i = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int rel;
    int acc;
    int base;
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_byte_i  = 8'h00;
    tick(3);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_tx_valid", tx_valid_o, 0);
    chk("rst_tx_byte", tx_byte_o, 8'h00);
    chk("rst_busy", busy_o, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("rst_level", level_o, 0);
`endif

    // Guard: write during guard, first issue only after 43 guard cycles.
    rst_i = 1'b0;
    rel   = cyc;
    tick();
    chk("guard_busy", busy_o, 1);
    chk("guard_wr_ready", wr_ready_o, 1);
    exp_q.push_back(8'hA5);
    send(8'hA5, acc);
    while (cyc < rel + 43) tick();
    chk("guard_no_tx", tx_count, 0);
    wait_tx(1, 20, "guard_tx_count");
    chk("guard_tx_cycle", last_tx_cyc, rel + 44);
    tick(12);
    chk("idle_busy", busy_o, 0);

    // Latency from write into empty FIFO: pulse at n+2 only.
    exp_q.push_back(8'h01);
    send(8'h01, acc);
    chk("lat_n1_valid", tx_valid_o, 0);
    tick();
    chk("lat_n2_valid", tx_valid_o, 1);
    chk("lat_n2_cycle", cyc, acc + 2);
    chk("lat_byte", tx_byte_o, 8'h01);
    tick();
    chk("lat_n3_valid", tx_valid_o, 0);
    chk("lat_hold_byte", tx_byte_o, 8'h01);
    tick(10);
    chk("lat_one_pulse", tx_count, 2);
    chk("lat_idle_busy", busy_o, 0);

    // Fill while busy; fifth byte is held until a pop frees a slot.
    done_dly = 20;
    base = tx_count;
    exp_q.push_back(8'hEE);
    send(8'hEE, acc);
    tick(3);
    b2b_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i), acc);
    end
    chk("full_ready_low", wr_ready_o, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("full_level", level_o, 4);
`endif
    exp_q.push_back(8'h14);
    send(8'h14, acc);
    chk("retry_accept_cycle", acc, done_rise_cyc + 1);
    wait_tx(base + 6, 400, "fill_tx_count");
    tick(30);
    b2b_en = 1'b0;

    // Full FIFO, pop and write in the same cycle: occupancy stays at DEPTH.
    base = tx_count;
    exp_q.push_back(8'h40);
    send(8'h40, acc);
    tick(3);
    b2b_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      send(8'h20 + 8'(i), acc);
    end
    exp_q.push_back(8'h77);
    send(8'h77, acc);
    chk("simul_accept_cycle", acc, done_rise_cyc + 1);
    chk("simul_still_full", wr_ready_o, 0);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("simul_level", level_o, 4);
`endif
    wait_tx(base + 6, 400, "simul_tx_count");
    tick(30);
    b2b_en = 1'b0;

    // Reset during WAIT_DONE with three bytes queued: all discarded.
    exp_q.push_back(8'h30);
    send(8'h30, acc);
    tick(3);
    send(8'h31, acc);
    send(8'h32, acc);
    send(8'h33, acc);
    base  = tx_count;
    rst_i = 1'b1;
    tick();
    chk("mid_rst_wr_ready", wr_ready_o, 0);
    chk("mid_rst_tx_valid", tx_valid_o, 0);
    rst_i = 1'b0;
    rel   = cyc;
    tick();
    chk("mid_rst_busy", busy_o, 1);
`ifdef UART_TX_FIFO_LEVEL_EN
    chk("mid_rst_level", level_o, 0);
`endif
    while (cyc < rel + 42) tick();
    chk("mid_rst_guard_busy", busy_o, 1);
    while (cyc < rel + 46) tick();
    chk("mid_rst_after_guard_busy", busy_o, 0);
    tick(20);
    chk("mid_rst_no_tx", tx_count, base);

    tick(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CCS_PER_BIT, default 217, giving clocks per bit of the downstream uart_tx.
REQ-002 SHALL have parameter DEPTH, default 16, giving FIFO entries; legal values are powers of two, minimum 2.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_byte_i  input  8  byte from the core.
REQ-006 SHALL have port wr_valid_i  input  1  write request; a write is accepted when wr_valid_i && wr_ready_o.
REQ-007 SHALL have port wr_ready_o  output  1  high when FIFO not full and not in reset.
REQ-008 SHALL have port tx_byte_o  output  8  byte to uart_tx tx_byte_i.
REQ-009 SHALL have port tx_valid_o  output  1  one-cycle start pulse to uart_tx tx_valid_i.
REQ-010 SHALL have port tx_done_i  input  1  from uart_tx tx_done_o; may stay high for several cycles.
REQ-011 SHALL have port busy_o  output  1  high when FIFO is non-empty or FSM is not IDLE.
REQ-012 SHALL have port level_o  output  $clog2(DEPTH)+1  FIFO occupancy; present only under UART_TX_FIFO_LEVEL_EN.

Function
REQ-013 SHALL store bytes first-in first-out, read and write pointers each $clog2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH; full when the pointers differ only in the MSB, empty when equal.
REQ-014 SHALL perform a simultaneous write and pop in one cycle with occupancy unchanged, including when full.
REQ-015 SHALL ignore wr_valid_i while wr_ready_o is low, with no state change and no overflow corruption.
REQ-016 SHALL implement FSM states GUARD, IDLE, ISSUE, WAIT_DONE.
REQ-017 GUARD: SHALL count down from 10*CCS_PER_BIT+2 to 0, then go to IDLE; no issues occur, and writes are still accepted.
REQ-018 IDLE: if non-empty, SHALL pop the head byte into a tx_byte_o register and go to ISSUE; otherwise remain.
REQ-019 ISSUE: SHALL drive tx_valid_o=1 for exactly this one cycle, then go to WAIT_DONE.
REQ-020 WAIT_DONE: SHALL go to IDLE on the first cycle tx_done_i is high while its registered previous value is low (rising edge); high levels without an edge are ignored.
REQ-021 SHALL hold tx_byte_o stable from ISSUE until the next pop.
REQ-022 Latency: for a write into an empty FIFO in IDLE at cycle n, tx_valid_o SHALL be high at cycle n+2.
REQ-023 Back-to-back: the next tx_valid_o SHALL occur 2 cycles after the tx_done_i rising edge.

Reset
REQ-024 On rst_i high, SHALL clear both pointers, set tx_valid_o=0, tx_byte_o=8'h00, wr_ready_o=0, level_o=0, and clear the done-edge register.
REQ-025 After reset deasserts, SHALL enter GUARD so that any byte in flight in uart_tx, which has no reset, completes before a new issue; busy_o=1 during GUARD.
REQ-026 A reset mid-ISSUE or mid-WAIT_DONE SHALL discard all queued bytes; a partially sent byte is not retransmitted.

Configuration
REQ-027 With UART_TX_FIFO_LEVEL_EN defined, SHALL provide level_o = write pointer minus read pointer, registered with the pointers.
REQ-028 Without UART_TX_FIFO_LEVEL_EN, level_o SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The FSM state enum (uart_tx_fifo_state_t) and the guard-count function of CCS_PER_BIT SHALL live in the shared package uart_pkg.
REQ-030 Storage and pointers SHALL be a sub-module sync_fifo (parameters DEPTH and WIDTH=8); the FSM stays in uart_tx_fifo.

Verification (CCS_PER_BIT=4, DEPTH=4, bench models uart_tx with tx_done high 2 cycles)
REQ-031 Reset, then write 8'hA5 during GUARD -> no tx_valid_o until 42 cycles after reset; then one pulse with tx_byte_o=8'hA5.
REQ-032 After guard, write 8'h01 to an empty FIFO at cycle n -> tx_valid_o=1 only at n+2; a 2-cycle tx_done_i yields one IDLE transition.
REQ-033 Write 5 bytes 8'h10..8'h14 back-to-back -> wr_ready_o drops after the 4th is accepted; when 8'h14 is offered while not ready it is dropped or held; transmitted order is 10,11,12,13, plus 14 only if retried.
REQ-034 Full FIFO with a pop and a write of 8'h77 in the same cycle -> level stays 4; 8'h77 is transmitted last.
REQ-035 Assert rst_i during WAIT_DONE with 3 bytes queued -> no further tx_valid_o; level_o=0; busy_o=1 until GUARD expires.
REQ-036 Build without UART_TX_FIFO_LEVEL_EN and rerun REQ-032 -> identical tx_byte_o/tx_valid_o traces.
